// File: rtl/updown_bcd_counter_if.sv
// Signal bundle for updown_bcd_counter: raw buttons, clear, and the BCD/segment outputs.
// The bench drives through master; the counter uses slave.
interface updown_bcd_counter_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  i_Up;
  logic                  i_Down;
  logic                  i_Clear;
  logic [4*DIGITS-1:0]   o_Bcd;
  logic [7*DIGITS-1:0]   o_Segments;
  logic                  o_Wrap;
  logic                  o_Toggle;

  modport master (
    output i_Up, i_Down, i_Clear,
    input  o_Bcd, o_Segments, o_Wrap, o_Toggle
  );

  modport slave (
    input  i_Up, i_Down, i_Clear,
    output o_Bcd, o_Segments, o_Wrap, o_Toggle
  );
endinterface

// File: rtl/updown_bcd_counter.sv
// Debounced up/down BCD counter with wrap pulse, step toggle and registered 7-segment decode.
// Define UPDOWN_AUTO_STEP_EN to add a periodic auto-increment tick.
module updown_bcd_counter #(
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned MAX_COUNT      = 99,
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned AUTO_PERIOD    = 500000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  updown_bcd_counter_if.slave   bus
);

  localparam int unsigned DBW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned         x;
    r = '0;
    x = v;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                b;
    r = v;
    b = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (b) begin
        if (r[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("updown_bcd_counter: DIGITS must be 1..4");
  end
  if (MAX_COUNT < 1 || MAX_COUNT >= 10**DIGITS) begin : g_bad_max
    $error("updown_bcd_counter: MAX_COUNT out of range for DIGITS");
  end
  if (DEBOUNCE_LIMIT < 1) begin : g_bad_deb
    $error("updown_bcd_counter: DEBOUNCE_LIMIT must be at least 1");
  end
  if (AUTO_PERIOD < 1) begin : g_bad_auto
    $error("updown_bcd_counter: AUTO_PERIOD must be at least 1");
  end

  // Channel 0 = up button, channel 1 = down button
  logic [1:0]     sync1_q, sync2_q, db_q, db_d, rel;
  logic [DBW-1:0] dbc_q [2];
  logic [DBW-1:0] dbc_d [2];

  always_comb begin
    db_d  = db_q;
    rel   = '0;
    dbc_d = '{default: '0};
    for (int unsigned ch = 0; ch < 2; ch++) begin
      if (sync2_q[ch] != db_q[ch]) begin
        if (dbc_q[ch] == DBW'(DEBOUNCE_LIMIT - 1)) begin
          db_d[ch] = sync2_q[ch];
          rel[ch]  = db_q[ch];
        end else begin
          dbc_d[ch] = dbc_q[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      dbc_q   <= '{default: '0};
    end else begin
      sync1_q <= {bus.i_Down, bus.i_Up};
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dbc_q   <= dbc_d;
    end
  end

  logic auto_tick;

`ifdef UPDOWN_AUTO_STEP_EN
  localparam int unsigned APW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  logic [APW-1:0] per_q, per_d;

  always_comb begin
    auto_tick = (per_q == APW'(AUTO_PERIOD - 1));
    per_d     = auto_tick ? '0 : per_q + 1'b1;
    if (bus.i_Clear) per_d = '0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) per_q <= '0;
    else          per_q <= per_d;
  end
`else
  assign auto_tick = 1'b0;
`endif

  logic                up_evt, dn_evt;
  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic [7*DIGITS-1:0] segs_q, segs_d;
  logic                wrap_q, wrap_d, tog_q, tog_d;

  assign up_evt = rel[0] | auto_tick;
  assign dn_evt = rel[1];

  // Simultaneous up and down cancel; clear overrides everything.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    tog_d  = tog_q;
    if (bus.i_Clear) begin
      cnt_d = '0;
    end else if (up_evt ^ dn_evt) begin
      tog_d = ~tog_q;
      if (up_evt) begin
        if (cnt_q == MAX_BCD) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = bcd_inc(cnt_q);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d  = MAX_BCD;
          wrap_d = 1'b1;
        end else begin
          cnt_d = bcd_dec(cnt_q);
        end
      end
    end
  end

  always_comb begin
    segs_d = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      segs_d[7*d +: 7] = seg7(cnt_q[4*d +: 4]);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q  <= '0;
      segs_q <= {DIGITS{7'h40}};
      wrap_q <= 1'b0;
      tog_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      segs_q <= segs_d;
      wrap_q <= wrap_d;
      tog_q  <= tog_d;
    end
  end

  assign bus.o_Bcd      = cnt_q;
  assign bus.o_Segments = segs_q;
  assign bus.o_Wrap     = wrap_q;
  assign bus.o_Toggle   = tog_q;

endmodule
